// File: rtl/alu_md_controller_pkg.sv
// rtl/alu_md_controller_pkg.sv - operation codes, ALUOp encodings and sequencer states
package alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } md_state_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    localparam logic [6:0] FUNCT7_M   = 7'b0000001;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SLL = 5'b00011;
    localparam logic [4:0] OP_SRL = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_SRA = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_BEQ = 5'b01000;
    localparam logic [4:0] OP_BNE = 5'b01001;
    localparam logic [4:0] OP_BLT = 5'b01010;
    localparam logic [4:0] OP_BGE = 5'b01011;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_LUI = 5'b01101;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

endpackage

// File: rtl/alu_md_controller_if.sv
// rtl/alu_md_controller_if.sv - EX-stage decode and multiply/divide handshake bundle
interface alu_md_controller_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 5
);
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            IsRType;
    logic            Start;
    logic            Flush;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [OP_W-1:0] Operation;
    logic            IsMD;
    logic            Stall;
    logic [XLEN-1:0] MDResult;
    logic            MDValid;

    modport master (
        output ALUOp, Funct7, Funct3, IsRType, Start, Flush, SrcA, SrcB,
        input  Operation, IsMD, Stall, MDResult, MDValid
    );

    modport slave (
        input  ALUOp, Funct7, Funct3, IsRType, Start, Flush, SrcA, SrcB,
        output Operation, IsMD, Stall, MDResult, MDValid
    );
endinterface

// File: rtl/alu_md_controller_md_divider.sv
// rtl/alu_md_controller_md_divider.sv - iterative unsigned restoring divider, one quotient bit per cycle
module md_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic [XLEN-1:0] cur_rem, cur_quo, cur_dsr, nxt_rem;
    logic [XLEN:0]   trial;
    logic            fits;
    logic            step;

    // The launch edge already performs the first iteration straight from the operands,
    // so done marks the cycle of the final iteration; results hold afterwards.
    assign step = (start | busy_q) & ~abort;
    assign done = busy_q & ~abort & (cnt_q == CW'(XLEN - 1));

    always_comb begin
        cur_rem = start ? '0 : rem_q;
        cur_quo = start ? dividend : quo_q;
        cur_dsr = start ? divisor : dsr_q;
        trial   = {cur_rem, cur_quo[XLEN-1]} - {1'b0, cur_dsr};
        fits    = ~trial[XLEN];
        nxt_rem = fits ? trial[XLEN-1:0] : {cur_rem[XLEN-2:0], cur_quo[XLEN-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else begin
            if (step) begin
                rem_q <= nxt_rem;
                quo_q <= {cur_quo[XLEN-2:0], fits};
                dsr_q <= cur_dsr;
            end
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(1);
            end else if (busy_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) busy_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/alu_md_controller.sv
// rtl/alu_md_controller.sv - ALU operation decoder with multi-cycle RV32M multiply/divide sequencer
module alu_md_controller
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_md_controller_if.slave   bus
);
    localparam int MCW = $clog2(MUL_LAT + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [4:0]      op5;
    logic            launch, is_div, signed_div, div_zero, overflow;
    logic            div_start, div_done;
    logic [XLEN-1:0] abs_a, abs_b, div_q, div_r, fix_q, fix_r, mul_sel;
    logic [2:0]      f3_q;
    logic            neg_q_q, neg_r_q;
    logic [XLEN-1:0] res_q;
    logic [MCW-1:0]  mul_cnt_q;
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, product;
    logic [2*XLEN-1:0] mul_pipe [MUL_LAT];

    always_comb begin
        op5 = OP_ADD;
        case (bus.ALUOp)
            ALUOP_MEM:  op5 = OP_ADD;
            ALUOP_JUMP: op5 = OP_LUI;
            ALUOP_BRANCH: begin
                case (bus.Funct3)
                    3'b000:  op5 = OP_BEQ;
                    3'b001:  op5 = OP_BNE;
                    3'b100:  op5 = OP_BLT;
                    3'b101:  op5 = OP_BGE;
                    default: op5 = OP_ADD;
                endcase
            end
            ALUOP_RTYPE: begin
                if (bus.IsRType && bus.Funct7 == FUNCT7_M) begin
                    op5 = {2'b10, bus.Funct3};
                end else begin
                    case (bus.Funct3)
                        3'b000:  op5 = (bus.Funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
                        3'b001:  op5 = OP_SLL;
                        3'b010:  op5 = OP_SLT;
                        3'b011:  op5 = OP_SLT;
                        3'b100:  op5 = OP_XOR;
                        3'b101:  op5 = (bus.Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
                        3'b110:  op5 = OP_OR;
                        default: op5 = OP_AND;
                    endcase
                end
            end
            default: op5 = OP_ADD;
        endcase
    end

    assign bus.Operation = OP_W'(op5);
    assign bus.IsMD      = op5[4];

    assign is_div     = bus.Funct3[2];
    assign signed_div = is_div & ~bus.Funct3[0];
    assign div_zero   = (bus.SrcB == '0);
    assign overflow   = signed_div & (bus.SrcA == INT_MIN) & (bus.SrcB == '1);
    assign launch     = (state_q == ST_IDLE) & bus.Start & op5[4] & ~bus.Flush;
    assign div_start  = launch & is_div & ~div_zero & ~overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    if (!is_div)                  state_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                    else if (div_zero || overflow) state_d = ST_DONE;
                    else                          state_d = ST_DIV;
                end
            end
            ST_MUL:  if (mul_cnt_q == MCW'(MUL_LAT - 1)) state_d = ST_DONE;
            ST_DIV:  if (div_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.Flush) state_d = ST_IDLE;
    end

    assign bus.Stall = ((state_q == ST_IDLE) & bus.Start & op5[4])
                     | (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX);

    // Full 2*XLEN product with per-operand sign extension covers MUL/MULH/MULHSU/MULHU.
    assign a_sgn   = (bus.Funct3 == 3'b001) | (bus.Funct3 == 3'b010);
    assign b_sgn   = (bus.Funct3 == 3'b001);
    assign a_ext   = {{XLEN{a_sgn & bus.SrcA[XLEN-1]}}, bus.SrcA};
    assign b_ext   = {{XLEN{b_sgn & bus.SrcB[XLEN-1]}}, bus.SrcB};
    assign product = a_ext * b_ext;

    assign abs_a = (signed_div & bus.SrcA[XLEN-1]) ? -bus.SrcA : bus.SrcA;
    assign abs_b = (signed_div & bus.SrcB[XLEN-1]) ? -bus.SrcB : bus.SrcB;

    md_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (reset),
        .start     (div_start),
        .abort     (bus.Flush),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign fix_q = neg_q_q ? -div_q : div_q;
    assign fix_r = neg_r_q ? -div_r : div_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f3_q      <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            res_q     <= '0;
            mul_cnt_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            mul_pipe[0] <= product;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
            if (launch) begin
                f3_q      <= bus.Funct3;
                neg_q_q   <= signed_div & (bus.SrcA[XLEN-1] ^ bus.SrcB[XLEN-1]);
                neg_r_q   <= signed_div & bus.SrcA[XLEN-1];
                mul_cnt_q <= MCW'(1);
                if (div_zero)      res_q <= bus.Funct3[1] ? bus.SrcA : '1;
                else if (overflow) res_q <= bus.Funct3[1] ? '0 : INT_MIN;
            end else if (state_q == ST_MUL) begin
                mul_cnt_q <= mul_cnt_q + MCW'(1);
            end
            if (state_q == ST_FIX) res_q <= f3_q[1] ? fix_r : fix_q;
        end
    end

    assign mul_sel = (f3_q == 3'b000) ? mul_pipe[MUL_LAT-1][XLEN-1:0]
                                      : mul_pipe[MUL_LAT-1][2*XLEN-1:XLEN];

    assign bus.MDValid  = (state_q == ST_DONE);
    assign bus.MDResult = (state_q == ST_DONE) ? (f3_q[2] ? res_q : mul_sel) : '0;
endmodule
